sr_excitation_driver: RTL and testbench

- Sequencer that drives a bank of WIDTH clocked SR flip-flops to a requested target vector.
- Accepts a target over a valid/ready handshake and computes per-bit S/R excitation from the bank's current outputs (the inverse of the SR characteristic table).
- Drives S/R for one cycle, then reads the bank back and retries on mismatch.
- Sits in front of the SR flip-flop bank; guarantees the prohibited S=R=1 input is never issued.

---
 rtl/sr_pkg.sv | 30 +++
 rtl/sr_excite.sv | 26 ++
 rtl/sr_excitation_driver.sv | 111 +++++++++++
 tb/tb_sr_excitation_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types for the SR flip-flop excitation driver: sequencer states and
// per-bit {s,r} excitation codes.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_PROH = 2'b11;

    // Inverse of the SR characteristic table. Don't-cares resolve to hold.
    function automatic logic [1:0] sr_code(input logic cur, input logic tgt);
        logic [1:0] code;
        code = SR_HOLD;
        if (tgt && !cur)
            code = SR_SET;
        else if (!tgt && cur)
            code = SR_RST;
        // Defensive guard: the prohibited S=R=1 pair can never leave here.
        if (code == SR_PROH)
            code = SR_HOLD;
        return code;
    endfunction

endpackage

// File: rtl/sr_excite.sv
// Combinational per-bit S/R excitation from the bank's current outputs and
// the requested target.
module sr_excite
    import sr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] s_n,
    output logic [WIDTH-1:0] r_n
);

    always_comb begin
        logic [1:0] code;
        code = SR_HOLD;
        s_n  = '0;
        r_n  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            code   = sr_code(cur[i], tgt[i]);
            s_n[i] = code[1];
            r_n[i] = code[0];
        end
    end

endmodule

// File: rtl/sr_excitation_driver.sv
// Sequencer that drives a bank of SR flip-flops to a requested vector:
// drive one cycle, read back, retry up to MAX_RETRY times on mismatch.
module sr_excitation_driver
    import sr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] fb_y,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] mismatch,
    output logic [CNT_W-1:0] retry_cnt
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is only high in IDLE, no queuing.

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

    state_t           state;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] ex_tgt;
    logic [WIDTH-1:0] s_n;
    logic [WIDTH-1:0] r_n;
    logic             accept;

    // On the accept edge tgt_q is not loaded yet, so excite from the request.
    assign ex_tgt = (state == IDLE) ? req_target : tgt_q;
    assign accept = req_valid && req_ready;

    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .cur (fb_y),
        .tgt (ex_tgt),
        .s_n (s_n),
        .r_n (r_n)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            tgt_q     <= '0;
            s         <= '0;
            r         <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mismatch  <= '0;
            retry_cnt <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            s     <= '0;
            r     <= '0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept) begin
                        tgt_q     <= req_target;
                        mismatch  <= '0;
                        retry_cnt <= '0;
                        s         <= s_n;
                        r         <= r_n;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (fb_y == tgt_q) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (retry_cnt < MAX_CNT) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        s         <= s_n;
                        r         <= r_n;
                        state     <= DRIVE;
                    end else begin
                        mismatch  <= fb_y ^ tgt_q;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Bench for sr_excitation_driver: behavioural SR bank with stuck-at-0 fault
// injection, directed requests, and a scoreboard of expected outcomes.
module tb_sr_excitation_driver;

    localparam int WIDTH     = 4;
    localparam int MAX_RETRY = 3;
    localparam int CNT_W     = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic [WIDTH-1:0] fb_y;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] mismatch;
    logic [CNT_W-1:0] retry_cnt;

    logic [WIDTH-1:0] bank;
    logic [WIDTH-1:0] stuck0;
    logic             load_en;
    logic [WIDTH-1:0] load_val;

    // Scoreboard entry: {is_error, retry_cnt, mismatch}
    logic [6:0] exp_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    sr_excitation_driver #(
        .WIDTH     (WIDTH),
        .MAX_RETRY (MAX_RETRY),
        .CNT_W     (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .fb_y       (fb_y),
        .s          (s),
        .r          (r),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .mismatch   (mismatch),
        .retry_cnt  (retry_cnt)
    );

    always #5 clock = ~clock;

    // Clocked SR bank: set/reset applied at the edge, stuck-at-0 bits masked.
    always @(posedge clock) begin
        if (load_en)
            bank <= load_val;
        else
            bank <= ((bank & ~r) | s) & ~stuck0;
    end
    assign fb_y = bank;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // The prohibited S=R=1 pair must never appear on any bit.
    always @(negedge clock) begin
        if ($time > 6) chk("s_and_r_zero", 16'(s & r), 16'h0);
    end

    task automatic load_bank(input logic [WIDTH-1:0] v);
        @(negedge clock);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clock);
        load_en  = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic [WIDTH-1:0] tgt);
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] exp_s;
        logic [WIDTH-1:0] exp_r;
        logic [WIDTH-1:0] final_y;
        logic             ok;
        logic [6:0]       entry;
        logic [6:0]       got;
        int               cyc;
        int               drives;
        logic             seen;
        int               waited;

        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        chk({tag, "_ready"}, 16'(req_ready), 16'h1);

        cur     = bank;
        exp_s   = tgt & ~cur;
        exp_r   = ~tgt & cur;
        final_y = tgt & ~stuck0;
        ok      = (final_y == tgt);
        entry   = ok ? {1'b0, 2'd0, 4'h0}
                     : {1'b1, 2'(MAX_RETRY), 4'(final_y ^ tgt)};
        exp_q.push_back(entry);

        req_valid  = 1'b1;
        req_target = tgt;
        @(posedge clock);
        #1 req_valid = 1'b0;

        seen   = 1'b0;
        drives = 0;
        cyc    = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clock);
            if (k == 1) begin
                chk({tag, "_drive_s"}, 16'(s), 16'(exp_s));
                chk({tag, "_drive_r"}, 16'(r), 16'(exp_r));
                chk({tag, "_busy"}, 16'(busy), 16'h1);
            end
            if (s != 0) drives++;
            if (done || error) begin
                seen = 1'b1;
                cyc  = k;
            end
        end
        chk({tag, "_timeout"}, 16'(seen), 16'h1);

        if (seen) begin
            if (exp_q.size() > 0) begin
                entry = exp_q.pop_front();
                got   = {error, retry_cnt, mismatch};
                chk({tag, "_outcome"}, 16'(got), 16'(entry));
            end else begin
                chk({tag, "_sb_empty"}, 16'h1, 16'h0);
            end
            chk({tag, "_done"}, 16'(done), 16'(ok));
            chk({tag, "_latency"}, 16'(cyc), ok ? 16'd3 : 16'(1 + 2 * (MAX_RETRY + 1)));
            chk({tag, "_ready_at_end"}, 16'(req_ready), 16'h1);
            chk({tag, "_busy_at_end"}, 16'(busy), 16'h0);
            if (!ok || exp_s != 0)
                chk({tag, "_drives"}, 16'(drives), ok ? 16'd1 : 16'(MAX_RETRY + 1));
            else
                chk({tag, "_no_drive"}, 16'(drives), 16'd0);
        end
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_target = '0;
        stuck0     = '0;
        load_en    = 1'b0;
        load_val   = '0;

        // Reset held for two edges
        repeat (2) begin
            @(negedge clock);
            chk("rst_sr", 16'({s, r}), 16'h0);
            chk("rst_ready", 16'(req_ready), 16'h0);
            chk("rst_flags", 16'({busy, done, error}), 16'h0);
            chk("rst_regs", 16'({mismatch, retry_cnt}), 16'h0);
        end
        reset = 1'b1;
        @(negedge clock);
        chk("release_ready", 16'(req_ready), 16'h1);

        load_bank(4'b0000);
        run_req("set_1010", 4'b1010);

        load_bank(4'b1100);
        run_req("mixed_0110", 4'b0110);
        chk("bank_after_mixed", 16'(bank), 16'h6);

        load_bank(4'b0000);
        stuck0 = 4'b0001;
        run_req("stuck_0001", 4'b0001);
        stuck0 = 4'b0000;

        // retry_cnt and mismatch hold after error until next accept
        @(negedge clock);
        chk("hold_retry", 16'(retry_cnt), 16'(MAX_RETRY));
        chk("hold_mismatch", 16'(mismatch), 16'h1);

        load_bank(4'b0101);
        run_req("same_0101", 4'b0101);

        // Reset while driving 1111: request is dropped silently
        @(negedge clock);
        req_valid  = 1'b1;
        req_target = 4'b1111;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        chk("abort_drive_s", 16'(s), 16'hA);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_sr", 16'({s, r}), 16'h0);
        chk("abort_ready", 16'(req_ready), 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("abort_no_flags", 16'({done, error}), 16'h0);
        end

        load_bank(4'b0000);
        run_req("after_abort_0011", 4'b0011);

        chk("sb_drained", 16'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
